// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Hazard detection and operand forwarding for the MIPS150 pipeline.
// Keeps a short shift register of destination registers for the producer
// stages behind ID, picks the youngest matching producer for each ALU
// operand, stalls ID on load-use hazards, and counts stall cycles.
// Internally stage 1 (youngest) lives at array index 0.

module hazard_forward_unit #(
  parameter  int NUM_STAGES = 3,
  parameter  int LOAD_LAT   = 1,
  parameter  int REG_AW     = 5,
  parameter  int CNT_W      = 32,
  localparam int SELW       = $clog2(NUM_STAGES + 1),
  localparam int LCW        = $clog2(LOAD_LAT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [SELW-1:0]   fwd_sel_a,
  output logic [SELW-1:0]   fwd_sel_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  // Per-stage producer state: valid, destination register, load countdown.
  logic [NUM_STAGES-1:0] stage_v;
  logic [REG_AW-1:0]     stage_addr [NUM_STAGES];
  logic [LCW-1:0]        stage_cnt  [NUM_STAGES];

  // Per-stage match vectors for each source operand.
  logic [NUM_STAGES-1:0] match_a;
  logic [NUM_STAGES-1:0] match_b;

  // Hazard flags derived from the selected (youngest) producer.
  logic hazard_a;
  logic hazard_b;

  // Value entering stage 1 on the next edge.
  logic              load_v;
  logic [REG_AW-1:0] load_addr;
  logic [LCW-1:0]    load_cnt;

  // Compare each tracked destination against both sources; r0 never matches.
  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      match_a[k] = stage_v[k] && (stage_addr[k] == id_rs) &&
                   (id_rs != '0) && id_rs_used;
      match_b[k] = stage_v[k] && (stage_addr[k] == id_rt) &&
                   (id_rt != '0) && id_rt_used;
    end
  end

  // Priority-select the youngest matching stage; scan oldest-first so the
  // youngest assignment is the one that sticks.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    hazard_a  = 1'b0;
    hazard_b  = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (match_a[k]) begin
        fwd_sel_a = SELW'(k + 1);
        hazard_a  = (stage_cnt[k] != '0);
      end
      if (match_b[k]) begin
        fwd_sel_b = SELW'(k + 1);
        hazard_b  = (stage_cnt[k] != '0);
      end
    end
  end

  // A flushed or invalid ID instruction can never stall the pipe.
  always_comb begin
    stall = id_valid && !flush && (hazard_a || hazard_b);
  end

  // Decide what enters stage 1: a real producer or a bubble.
  always_comb begin
    load_v    = 1'b0;
    load_addr = '0;
    load_cnt  = '0;
    if (!stall && !flush && id_valid && id_wr_en && (id_wr_addr != '0)) begin
      load_v    = 1'b1;
      load_addr = id_wr_addr;
      load_cnt  = id_is_load ? LCW'(LOAD_LAT) : '0;
    end
  end

  // Shift the producer tracker every cycle, aging load countdowns to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_v <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        stage_addr[k] <= '0;
        stage_cnt[k]  <= '0;
      end
    end else begin
      for (int k = NUM_STAGES - 1; k > 0; k--) begin
        stage_v[k]    <= stage_v[k-1];
        stage_addr[k] <= stage_addr[k-1];
        stage_cnt[k]  <= (stage_cnt[k-1] != '0) ? (stage_cnt[k-1] - LCW'(1)) : '0;
      end
      stage_v[0]    <= load_v;
      stage_addr[0] <= load_addr;
      stage_cnt[0]  <= load_cnt;
    end
  end

  // Saturating stall-cycle counter for performance measurement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit
// Directed scoreboard bench: one instance with default parameters and one
// with NUM_STAGES=4, LOAD_LAT=3, CNT_W=4. Both share the ID-side inputs and
// have independent resets.

module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset2;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        id_wr_en;
  logic [4:0]  id_wr_addr;
  logic        id_is_load;
  logic        flush;

  logic [1:0]  fwd_sel_a;
  logic [1:0]  fwd_sel_b;
  logic        stall;
  logic [31:0] stall_count;

  logic [2:0]  fwd_sel_a2;
  logic [2:0]  fwd_sel_b2;
  logic        stall2;
  logic [3:0]  stall_count2;

  typedef struct {
    string       tag;
    int          dut;
    logic [2:0]  sel_a;
    logic [2:0]  sel_b;
    logic        stall;
    logic [31:0] count;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  hazard_forward_unit dut1 (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .id_wr_en    (id_wr_en),
    .id_wr_addr  (id_wr_addr),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .fwd_sel_a   (fwd_sel_a),
    .fwd_sel_b   (fwd_sel_b),
    .stall       (stall),
    .stall_count (stall_count)
  );

  hazard_forward_unit #(
    .NUM_STAGES (4),
    .LOAD_LAT   (3),
    .REG_AW     (5),
    .CNT_W      (4)
  ) dut2 (
    .clk         (clk),
    .reset       (reset2),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .id_wr_en    (id_wr_en),
    .id_wr_addr  (id_wr_addr),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .fwd_sel_a   (fwd_sel_a2),
    .fwd_sel_b   (fwd_sel_b2),
    .stall       (stall2),
    .stall_count (stall_count2)
  );

  function automatic logic [31:0] sat15(input int c);
    return (c > 15) ? 32'd15 : 32'(c);
  endfunction

  task automatic push_expect(input string tag, input int dut, input int ea, input int eb,
                             input int es, input int ec);
    exp_t e;
    e.tag   = tag;
    e.dut   = dut;
    e.sel_a = 3'(ea);
    e.sel_b = 3'(eb);
    e.stall = (es != 0);
    e.count = 32'(ec);
    sb_q.push_back(e);
  endtask

  task automatic apply_stimulus(input int valid, input int rs, input int rt, input int rs_used,
                                input int rt_used, input int wr_en, input int wr_addr,
                                input int is_load, input int flsh);
    id_valid   = (valid != 0);
    id_rs      = 5'(rs);
    id_rt      = 5'(rt);
    id_rs_used = (rs_used != 0);
    id_rt_used = (rt_used != 0);
    id_wr_en   = (wr_en != 0);
    id_wr_addr = 5'(wr_addr);
    id_is_load = (is_load != 0);
    flush      = (flsh != 0);
  endtask

  task automatic check_output();
    exp_t        e;
    logic [2:0]  oa;
    logic [2:0]  ob;
    logic        os;
    logic [31:0] oc;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    if (e.dut == 1) begin
      oa = {1'b0, fwd_sel_a};
      ob = {1'b0, fwd_sel_b};
      os = stall;
      oc = stall_count;
    end else begin
      oa = fwd_sel_a2;
      ob = fwd_sel_b2;
      os = stall2;
      oc = {28'd0, stall_count2};
    end
    checks++;
    assert (os === e.stall) else begin
      errors++;
      $error("[TB] FAIL %s stall observed=%0b expected=%0b", e.tag, os, e.stall);
    end
    if (!e.stall) begin
      checks++;
      assert (oa === e.sel_a) else begin
        errors++;
        $error("[TB] FAIL %s fwd_sel_a observed=%0d expected=%0d", e.tag, oa, e.sel_a);
      end
      checks++;
      assert (ob === e.sel_b) else begin
        errors++;
        $error("[TB] FAIL %s fwd_sel_b observed=%0d expected=%0d", e.tag, ob, e.sel_b);
      end
    end
    checks++;
    assert (oc === e.count) else begin
      errors++;
      $error("[TB] FAIL %s stall_count observed=%0d expected=%0d", e.tag, oc, e.count);
    end
  endtask

  // One pipeline cycle: drive ID after the falling edge, record the
  // expectation, then sample before the next rising edge.
  task automatic step(input string tag, input int dut,
                      input int valid, input int rs, input int rt, input int rs_used,
                      input int rt_used, input int wr_en, input int wr_addr,
                      input int is_load, input int flsh,
                      input int ea, input int eb, input int es, input int ec);
    @(negedge clk);
    apply_stimulus(valid, rs, rt, rs_used, rt_used, wr_en, wr_addr, is_load, flsh);
    push_expect(tag, dut, ea, eb, es, ec);
    #1;
    check_output();
  endtask

  // Directed sequence covering forwarding, load-use stalls, shadowing, r0,
  // flush priority, saturation and asynchronous reset.
  initial begin
    int c;
    reset  = 1'b0;
    reset2 = 1'b0;
    apply_stimulus(1, 3, 3, 1, 1, 1, 3, 1, 0);
    #11;
    push_expect("reset", 1, 0, 0, 0, 0);
    check_output();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    step("t1_prod",     1, 1, 1, 2, 1, 1, 1, 3, 0, 0,  0, 0, 0, 0);
    step("t1_s1",       1, 1, 3, 0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0);
    step("t1_s2",       1, 1, 3, 0, 1, 1, 0, 0, 0, 0,  2, 0, 0, 0);
    step("t1_s3",       1, 1, 3, 0, 1, 1, 0, 0, 0, 0,  3, 0, 0, 0);
    step("t1_s0",       1, 1, 3, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    step("t2_lw",       1, 1, 1, 0, 1, 0, 1, 5, 1, 0,  0, 0, 0, 0);
    step("t2_stall",    1, 1, 5, 0, 1, 1, 1, 6, 0, 0,  0, 0, 1, 0);
    step("t2_fwd",      1, 1, 5, 0, 1, 1, 1, 6, 0, 0,  2, 0, 0, 1);
    step("t3_a",        1, 1, 0, 0, 1, 0, 1, 4, 0, 0,  0, 0, 0, 1);
    step("t3_b",        1, 1, 4, 0, 1, 0, 1, 4, 0, 0,  1, 0, 0, 1);
    step("t3_use",      1, 1, 6, 4, 1, 1, 1, 7, 0, 0,  3, 1, 0, 1);
    step("t3_shadow",   1, 1, 4, 4, 1, 1, 0, 0, 0, 0,  2, 2, 0, 1);
    step("t4_w0",       1, 1, 0, 0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 1);
    step("t4_r0",       1, 1, 0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 1);
    step("t5_lw",       1, 1, 0, 0, 0, 0, 1, 8, 1, 0,  0, 0, 0, 1);
    step("t5_flush",    1, 1, 8, 0, 1, 0, 1, 9, 0, 1,  1, 0, 0, 1);
    step("t5_after",    1, 1, 9, 8, 1, 1, 0, 0, 0, 0,  0, 2, 0, 1);
    step("t5_lw2",      1, 1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 1);
    step("t5_invalid",  1, 0, 10, 0, 1, 0, 1, 12, 0, 0, 1, 0, 0, 1);
    step("t6_lw",       1, 1, 0, 0, 0, 0, 1, 11, 1, 0, 0, 0, 0, 1);
    step("t6_rt_stall", 1, 1, 10, 11, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    step("t6_rt_fwd",   1, 1, 10, 11, 1, 1, 0, 0, 0, 0, 0, 2, 0, 2);

    reset2 = 1'b1;
    c = 0;
    for (int i = 0; i < 6; i++) begin
      step("p2_lw", 2, 1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, int'(sat15(c)));
      for (int j = 0; j < 3; j++) begin
        step("p2_stall", 2, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, int'(sat15(c)));
        c++;
      end
      step("p2_fwd", 2, 1, 7, 0, 1, 0, 0, 0, 0, 0, 4, 0, 0, int'(sat15(c)));
    end
    step("p2_sat",       2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15);
    step("p2_lw_r",      2, 1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 15);
    step("p2_pre_reset", 2, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 15);
    #2;
    reset2 = 1'b0;
    #1;
    push_expect("p2_reset", 2, 0, 0, 0, 0);
    check_output();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
